inst_encoder_loader: RTL and testbench

//  Inverse of the pipeline control decoder: takes mnemonic-level instruction requests,

---
 rtl/inst_encoder_loader_pkg.sv | 59 +++++
 rtl/inst_encoder_loader_enc.sv | 38 +++
 rtl/inst_encoder_loader.sv | 129 ++++++++++++
 tb/tb_inst_encoder_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_loader_pkg.sv
// Shared encodings for the instruction encoder/loader: mnemonic codes,
// MIPS opcode/func fields, FSM states and word-packing helpers.
package inst_encoder_loader_pkg;

    // Mnemonic codes presented on in_mnem; 14 and 15 are illegal
    localparam logic [3:0] MnNop  = 4'd0;
    localparam logic [3:0] MnAdd  = 4'd1;
    localparam logic [3:0] MnSub  = 4'd2;
    localparam logic [3:0] MnSlt  = 4'd3;
    localparam logic [3:0] MnAnd  = 4'd4;
    localparam logic [3:0] MnOr   = 4'd5;
    localparam logic [3:0] MnJr   = 4'd6;
    localparam logic [3:0] MnAddi = 4'd7;
    localparam logic [3:0] MnSlti = 4'd8;
    localparam logic [3:0] MnLw   = 4'd9;
    localparam logic [3:0] MnSw   = 4'd10;
    localparam logic [3:0] MnBeq  = 4'd11;
    localparam logic [3:0] MnJ    = 4'd12;
    localparam logic [3:0] MnJal  = 4'd13;

    // Primary opcodes
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    // R-type func codes
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnSlt = 6'b101010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnJr  = 6'b001000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {OpRtype, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/inst_encoder_loader_enc.sv
// Combinational mnemonic-to-MIPS-word encoder with illegal-mnemonic flag.
module inst_encoder
    import inst_encoder_loader_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the instruction format and fill only the fields it uses
    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (mnem)
            MnNop:   word = 32'd0;
            MnAdd:   word = r_word(rs, rt, rd, FnAdd);
            MnSub:   word = r_word(rs, rt, rd, FnSub);
            MnSlt:   word = r_word(rs, rt, rd, FnSlt);
            MnAnd:   word = r_word(rs, rt, rd, FnAnd);
            MnOr:    word = r_word(rs, rt, rd, FnOr);
            MnJr:    word = r_word(rs, 5'd0, 5'd0, FnJr);
            MnAddi:  word = i_word(OpAddi, rs, rt, imm);
            MnSlti:  word = i_word(OpSlti, rs, rt, imm);
            MnLw:    word = i_word(OpLw, rs, rt, imm);
            MnSw:    word = i_word(OpSw, rs, rt, imm);
            MnBeq:   word = i_word(OpBeq, rs, rt, imm);
            MnJ:     word = j_word(OpJ, target);
            MnJal:   word = j_word(OpJal, target);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Streams encoded instructions into instruction memory, one word per accepted
// request, with a one-cycle registered write port.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned     Depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);
    localparam logic [ADDR_W-1:0] BasePtr = ADDR_W'(BASE_ADDR);

    state_e              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     count_q;
    logic                err_q;
    logic                done_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;

    logic [31:0] enc_word;
    logic        enc_illegal;
    logic        full;
    logic        accept;
    logic        overflow;

    inst_encoder u_enc (
        .mnem    (in_mnem),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // Handshake and overflow qualification
    always_comb begin
        full     = (count_q == DepthCnt);
        in_ready = (state_q == StLoad) && !full && !start;
        accept   = in_valid && in_ready;
        overflow = (state_q == StLoad) && full && in_valid && !start;
    end

    // FSM, pointer/count and registered write port; count advances with the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= BasePtr;
            count_q     <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (start) begin
                // Any pending registered write still issues this cycle
                state_q <= StLoad;
                ptr_q   <= BasePtr;
                count_q <= '0;
                err_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    StLoad: begin
                        if (overflow) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (accept) begin
                            if (enc_illegal) begin
                                err_q <= 1'b1;
                                if (in_last) begin
                                    done_q  <= 1'b1;
                                    state_q <= StDone;
                                end
                            end else begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= ptr_q;
                                mem_wdata_q <= enc_word;
                                ptr_q       <= ptr_q + 1'b1;
                                count_q     <= count_q + 1'b1;
                                // done follows one cycle after this final write
                                if (in_last) state_q <= StDone;
                            end
                        end
                    end
                    StDone:  done_q <= 1'b1;
                    StIdle:  ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == StLoad);
    assign done      = done_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench: a main loader (ADDR_W=10, BASE 0) and a small one
// (ADDR_W=2, BASE 2) sharing request fields, selected by sel.
module tb_inst_encoder_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, in_valid, in_last, sel;
    logic [3:0]  in_mnem;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic m_start, m_valid, s_start, s_valid;
    assign m_start = start & ~sel;
    assign m_valid = in_valid & ~sel;
    assign s_start = start & sel;
    assign s_valid = in_valid & sel;

    logic        m_ready, m_we, m_busy, m_done, m_err;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata;
    logic [10:0] m_count;
    logic        s_ready, s_we, s_busy, s_done, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    inst_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) u_main (
        .clk(clk), .rst(rst), .start(m_start), .in_valid(m_valid), .in_ready(m_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .mem_we(m_we), .mem_addr(m_addr),
        .mem_wdata(m_wdata), .busy(m_busy), .done(m_done), .err(m_err), .count(m_count)
    );

    inst_encoder_loader #(.ADDR_W(2), .BASE_ADDR(2)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last), .mem_we(s_we), .mem_addr(s_addr),
        .mem_wdata(s_wdata), .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
    );

    int errors = 0;
    int checks = 0;

    // Expected writes: {addr[9:0], data[31:0]} per DUT
    logic [41:0] q0[$];
    logic [41:0] q1[$];
    int exp_cnt[2];
    bit exp_err[2];
    int base_of[2]  = '{0, 2};
    int depth_of[2] = '{1024, 4};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from field positions: op[31:26] rs[25:21] rt[20:16]
    // rd[15:11] shamt[10:6] func[5:0] imm[15:0] target[25:0]
    function automatic logic [31:0] ref_enc(input int m, input int rs, input int rt,
                                            input int rd, input int imm, input int tg);
        logic [31:0] op, fn, w;
        op = 0; fn = 0; w = 0;
        case (m)
            1: fn = 32;  2: fn = 34;  3: fn = 42;  4: fn = 36;  5: fn = 37;
            7: op = 8;   8: op = 10;  9: op = 35;  10: op = 43; 11: op = 4;
            12: op = 2;  13: op = 3;
            default: ;
        endcase
        if (m >= 1 && m <= 5)
            w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | fn;
        else if (m == 6)
            w = (32'(rs) << 21) | 32'd8;
        else if (m >= 7 && m <= 11)
            w = (op << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        else if (m == 12 || m == 13)
            w = (op << 26) | 32'(tg);
        return w;
    endfunction

    // Monitors: pop and compare on every presented write
    always @(negedge clk) begin
        if (m_we === 1'b1) begin
            if (q0.size() == 0) chk("main_unexpected_write", 32'(m_we), 32'd0);
            else begin
                logic [41:0] e;
                e = q0.pop_front();
                chk("main_addr", 32'(m_addr), 32'(e[41:32]));
                chk("main_wdata", m_wdata, e[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (s_we === 1'b1) begin
            if (q1.size() == 0) chk("small_unexpected_write", 32'(s_we), 32'd0);
            else begin
                logic [41:0] e;
                e = q1.pop_front();
                chk("small_addr", 32'(s_addr), 32'(e[41:32]));
                chk("small_wdata", s_wdata, e[31:0]);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_s(input bit sl);
        sel = sl;
        start = 1'b1;
        idle(1);
        start = 1'b0;
        exp_cnt[sl] = 0;
        exp_err[sl] = 1'b0;
    endtask

    task automatic send(input bit sl, input int m, input int rs, input int rt, input int rd,
                        input int imm, input int tg, input bit last);
        logic rdy;
        int n;
        logic [31:0] a;
        sel = sl;
        in_mnem = 4'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_imm = 16'(imm); in_target = 26'(tg); in_last = last;
        in_valid = 1'b1;
        #1;
        n = 0;
        do begin
            rdy = sl ? s_ready : m_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("ready_timeout", 32'(rdy), 32'd1);
        else if (m > 13) exp_err[sl] = 1'b1;
        else begin
            a = 32'((base_of[sl] + exp_cnt[sl]) % depth_of[sl]);
            if (sl) q1.push_back({a[9:0], ref_enc(m, rs, rt, rd, imm, tg)});
            else    q0.push_back({a[9:0], ref_enc(m, rs, rt, rd, imm, tg)});
            exp_cnt[sl]++;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic check_end(input bit sl);
        idle(2);
        if (!sl) begin
            chk("main_count", 32'(m_count), 32'(exp_cnt[0]));
            chk("main_err", 32'(m_err), 32'(exp_err[0]));
            chk("main_done", 32'(m_done), 32'd1);
            chk("main_busy", 32'(m_busy), 32'd0);
            chk("main_ready", 32'(m_ready), 32'd0);
            chk("main_sb_empty", 32'(q0.size()), 32'd0);
        end else begin
            chk("small_count", 32'(s_count), 32'(exp_cnt[1]));
            chk("small_err", 32'(s_err), 32'(exp_err[1]));
            chk("small_done", 32'(s_done), 32'd1);
            chk("small_busy", 32'(s_busy), 32'd0);
            chk("small_sb_empty", 32'(q1.size()), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; sel = 1'b0;
        in_mnem = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_imm = 0; in_target = 0;
        exp_cnt = '{0, 0};
        exp_err = '{1'b0, 1'b0};
        #3;
        chk("rst_we", 32'(m_we), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_count", 32'(m_count), 32'd0);
        chk("rst_small_count", 32'(s_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        chk("idle_ready", 32'(m_ready), 32'd0);

        // 1: single add
        start_s(0);
        chk("load_busy", 32'(m_busy), 32'd1);
        send(0, 1, 1, 2, 3, 0, 0, 0);
        idle(1);
        chk("count_after_add", 32'(m_count), 32'd1);

        // 2 + 3: back-to-back stream, then jumps ending the session
        start_s(0);
        send(0, 7, 0, 5, 0, 10, 0, 0);
        send(0, 9, 1, 4, 0, 8, 0, 0);
        send(0, 11, 1, 2, 0, 16'hFFFF, 0, 0);
        send(0, 6, 31, 0, 0, 0, 0, 0);
        idle(1);
        chk("count_after_four", 32'(m_count), 32'd4);
        send(0, 12, 0, 0, 0, 0, 26'h100, 0);
        send(0, 13, 0, 0, 0, 0, 26'h40, 1);
        chk("done_not_with_write", 32'(m_done), 32'd0);
        check_end(0);

        // 4: illegal mnemonic mid-stream
        start_s(0);
        send(0, 1, 4, 5, 6, 0, 0, 0);
        send(0, 15, 1, 1, 1, 0, 0, 0);
        idle(1);
        chk("err_after_illegal", 32'(m_err), 32'd1);
        send(0, 2, 7, 8, 9, 0, 0, 0);
        send(0, 14, 0, 0, 0, 0, 0, 1);
        check_end(0);
        start_s(0);
        chk("start_clears_err", 32'(m_err), 32'd0);
        chk("start_clears_done", 32'(m_done), 32'd0);

        // Randomized sessions with random gaps
        for (int s = 0; s < 6; s++) begin
            int n;
            start_s(0);
            n = $urandom_range(3, 20);
            for (int i = 0; i < n; i++) begin
                send(0, $urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 65535),
                     $urandom_range(0, 32'h3FFFFFF), (i == n - 1));
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            end
            check_end(0);
        end

        // 5: small memory wraps 2,3,0,1 then overflows
        start_s(1);
        for (int i = 0; i < 4; i++)
            send(1, $urandom_range(1, 13), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 65535),
                 $urandom_range(0, 32'h3FFFFFF), 0);
        sel = 1'b1;
        in_valid = 1'b1;
        idle(1);
        in_valid = 1'b0;
        exp_err[1] = 1'b1;
        chk("ovf_err", 32'(s_err), 32'd1);
        chk("ovf_done", 32'(s_done), 32'd1);
        chk("ovf_no_write", 32'(s_we), 32'd0);
        check_end(1);

        // 6: reset pulse while a write is presented
        start_s(0);
        send(0, 5, 1, 2, 3, 0, 0, 0);
        send(0, 4, 3, 2, 1, 0, 0, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(m_we), 32'd0);
        chk("arst_busy", 32'(m_busy), 32'd0);
        chk("arst_count", 32'(m_count), 32'd0);
        chk("arst_ready", 32'(m_ready), 32'd0);
        q0.delete();
        q1.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        chk("post_rst_ready", 32'(m_ready), 32'd0);
        start_s(0);
        send(0, 3, 9, 10, 11, 0, 0, 0);
        send(0, 10, 2, 3, 0, 16'h8000, 0, 1);
        check_end(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
